// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// Latency: none, wires only.
// Backpressure: mem_ready is the only handshake; the controller holds its outputs while it is low.
// Ports: op/funct3 from the instruction register, Zero from the ALU, mem_ready from memory;
//        mux selects, ALUOp, ImmSrc, write enables and illegal back to the datapath.
interface multicycle_ctrl_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       Zero;
   logic       mem_ready;

   logic [2:0] ImmSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] ResultSrc;
   logic       AdrSrc;
   logic       IRWrite;
   logic       PCWrite;
   logic       RegWrite;
   logic       MemWrite;
   logic       illegal;

   // Controller side.
   modport master (
      input  op, funct3, Zero, mem_ready,
      output ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
             AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal
   );

   // Datapath side.
   modport slave (
      output op, funct3, Zero, mem_ready,
      input  ImmSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
             AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, illegal
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// Control FSM sequencing the shared ALU, memory port and register file of a multicycle RV32I core.
// Latency: 2-5 cycles per instruction plus one per cycle mem_ready is low in FETCH/MEMREAD/MEMWRITE.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold their outputs until mem_ready; other states ignore it.
// Ports: clk, rst_n (async active-low) plus ctrl_bus (master modport) carrying IR fields,
//        ALU zero, memory ready, and all datapath selects/enables.
module multicycle_ctrl (
   input  logic              clk,
   input  logic              rst_n,
   multicycle_ctrl_if.master ctrl_bus
);

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI
   } state_t;

   state_t     r_state;
   state_t     w_next_state;

   logic [2:0] w_imm_src;
   logic [1:0] w_alu_src_a;
   logic [1:0] w_alu_src_b;
   logic [1:0] w_alu_op;
   logic [1:0] w_result_src;
   logic       w_adr_src;
   logic       w_ir_write;
   logic       w_pc_write;
   logic       w_reg_write;
   logic       w_mem_write;
   logic       w_illegal;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next state and Moore outputs; only mem_ready (FETCH) and Zero (BRANCH) leak through.
   always_comb begin
      w_next_state = r_state;
      w_alu_src_a  = 2'b00;
      w_alu_src_b  = 2'b00;
      w_alu_op     = 2'b00;
      w_result_src = 2'b00;
      w_adr_src    = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_write  = 1'b0;
      w_illegal    = 1'b0;

      case (r_state)
         S_FETCH: begin
            // PC+4 is computed by the ALU and written back through ALUResult.
            w_alu_src_b  = 2'b10;
            w_result_src = 2'b10;
            w_ir_write   = ctrl_bus.mem_ready;
            w_pc_write   = ctrl_bus.mem_ready;
            if (ctrl_bus.mem_ready) begin
               w_next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch/jal target precomputed into ALUOut while the op is decoded.
            w_alu_src_a = 2'b01;
            w_alu_src_b = 2'b01;
            case (ctrl_bus.op)
               OP_LW, OP_SW: w_next_state = S_MEMADR;
               OP_R:         w_next_state = S_EXECR;
               OP_IALU:      w_next_state = S_EXECI;
               OP_BR:        w_next_state = S_BRANCH;
               OP_JAL:       w_next_state = S_JAL;
               OP_JALR:      w_next_state = S_JALR1;
               OP_LUI:       w_next_state = S_LUI;
               OP_AUIPC:     w_next_state = S_ALUWB;
               default: begin
                  w_illegal    = 1'b1;
                  w_next_state = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            w_alu_src_a  = 2'b10;
            w_alu_src_b  = 2'b01;
            w_next_state = (ctrl_bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            w_adr_src = 1'b1;
            if (ctrl_bus.mem_ready) begin
               w_next_state = S_MEMWB;
            end
         end
         S_MEMWB: begin
            w_result_src = 2'b01;
            w_reg_write  = 1'b1;
            w_next_state = S_FETCH;
         end
         S_MEMWRITE: begin
            w_adr_src   = 1'b1;
            w_mem_write = 1'b1;
            if (ctrl_bus.mem_ready) begin
               w_next_state = S_FETCH;
            end
         end
         S_EXECR: begin
            w_alu_src_a  = 2'b10;
            w_alu_op     = 2'b10;
            w_next_state = S_ALUWB;
         end
         S_EXECI: begin
            w_alu_src_a  = 2'b10;
            w_alu_src_b  = 2'b01;
            w_alu_op     = 2'b10;
            w_next_state = S_ALUWB;
         end
         S_ALUWB: begin
            w_reg_write  = 1'b1;
            w_next_state = S_FETCH;
         end
         S_BRANCH: begin
            // Target sits in ALUOut from DECODE; ALU compares rs1-rs2 this cycle.
            w_alu_src_a = 2'b10;
            w_alu_op    = 2'b01;
            case (ctrl_bus.funct3)
               3'b000:  w_pc_write = ctrl_bus.Zero;
               3'b001:  w_pc_write = ~ctrl_bus.Zero;
               default: w_pc_write = 1'b0;
            endcase
            w_next_state = S_FETCH;
         end
         S_JAL: begin
            // PC loads the target from ALUOut while the ALU forms OldPC+4 as the link.
            w_alu_src_a  = 2'b01;
            w_alu_src_b  = 2'b10;
            w_pc_write   = 1'b1;
            w_next_state = S_ALUWB;
         end
         S_JALR1: begin
            w_alu_src_a  = 2'b10;
            w_alu_src_b  = 2'b01;
            w_next_state = S_JALR2;
         end
         S_JALR2: begin
            w_alu_src_a  = 2'b01;
            w_alu_src_b  = 2'b10;
            w_pc_write   = 1'b1;
            w_next_state = S_ALUWB;
         end
         S_LUI: begin
            // 0 + U-immediate through the adder.
            w_alu_src_a  = 2'b11;
            w_alu_src_b  = 2'b01;
            w_next_state = S_ALUWB;
         end
         default: begin
            w_next_state = S_FETCH;
         end
      endcase
   end

   // Extender select follows the opcode everywhere except FETCH, where IR is still loading.
   always_comb begin
      w_imm_src = 3'b000;
      if (r_state != S_FETCH) begin
         case (ctrl_bus.op)
            OP_IALU:          w_imm_src = (ctrl_bus.funct3[1:0] == 2'b01) ? 3'b101 : 3'b000;
            OP_SW:            w_imm_src = 3'b001;
            OP_BR:            w_imm_src = 3'b010;
            OP_LUI, OP_AUIPC: w_imm_src = 3'b011;
            OP_JAL:           w_imm_src = 3'b100;
            default:          w_imm_src = 3'b000;
         endcase
      end
   end

   assign ctrl_bus.ImmSrc    = w_imm_src;
   assign ctrl_bus.ALUSrcA   = w_alu_src_a;
   assign ctrl_bus.ALUSrcB   = w_alu_src_b;
   assign ctrl_bus.ALUOp     = w_alu_op;
   assign ctrl_bus.ResultSrc = w_result_src;
   assign ctrl_bus.AdrSrc    = w_adr_src;

   // FETCH passes mem_ready straight through, so the enables are masked by reset
   // directly rather than relying on the state register alone.
   assign ctrl_bus.IRWrite   = rst_n & w_ir_write;
   assign ctrl_bus.PCWrite   = rst_n & w_pc_write;
   assign ctrl_bus.RegWrite  = rst_n & w_reg_write;
   assign ctrl_bus.MemWrite  = rst_n & w_mem_write;
   assign ctrl_bus.illegal   = rst_n & w_illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: random instruction stream with random memory stalls,
// checked cycle by cycle against a per-instruction phase list and the output table per phase.
// Also covers reset state, directed lw/branch/illegal cases, and async reset during MEMWRITE.
module tb_multicycle_ctrl;

   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   typedef enum int {
      PH_FETCH, PH_DECODE, PH_MEMADR, PH_MEMREAD, PH_MEMWB, PH_MEMWRITE,
      PH_EXECR, PH_EXECI, PH_ALUWB, PH_BRANCH, PH_JAL, PH_JALR1, PH_JALR2, PH_LUI
   } ph_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_errors = 0;
   ph_t  seq[$];

   always #5 clk = ~clk;

   multicycle_ctrl_if u_bus ();

   multicycle_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ctrl_bus (u_bus)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] obs_vec();
      return {u_bus.ImmSrc, u_bus.ALUSrcA, u_bus.ALUSrcB, u_bus.ALUOp, u_bus.ResultSrc,
              u_bus.AdrSrc, u_bus.IRWrite, u_bus.PCWrite, u_bus.RegWrite, u_bus.MemWrite,
              u_bus.illegal};
   endfunction

   function automatic logic [4:0] obs_enables();
      return {u_bus.IRWrite, u_bus.PCWrite, u_bus.RegWrite, u_bus.MemWrite, u_bus.illegal};
   endfunction

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {OP_LW, OP_IALU, OP_AUIPC, OP_SW, OP_R, OP_LUI, OP_BR, OP_JALR, OP_JAL};
   endfunction

   // Cycle counts as listed for each instruction class with no stalls.
   function automatic int cpi_base(input logic [6:0] op);
      case (op)
         OP_AUIPC, OP_BR:                  return 3;
         OP_R, OP_IALU, OP_LUI, OP_JAL, OP_SW: return 4;
         OP_LW, OP_JALR:                   return 5;
         default:                          return 2;
      endcase
   endfunction

   function automatic logic [2:0] imm_type(input logic [6:0] op, input logic [2:0] f3);
      if (op == OP_IALU && (f3 == 3'b001 || f3 == 3'b101)) return 3'b101;
      if (op == OP_SW)                                     return 3'b001;
      if (op == OP_BR)                                     return 3'b010;
      if (op == OP_LUI || op == OP_AUIPC)                  return 3'b011;
      if (op == OP_JAL)                                    return 3'b100;
      return 3'b000;
   endfunction

   // Phase list an instruction walks through, ignoring stalls.
   function automatic void build_seq(input logic [6:0] op);
      seq = {PH_FETCH, PH_DECODE};
      case (op)
         OP_LW:    seq = {seq, PH_MEMADR, PH_MEMREAD, PH_MEMWB};
         OP_SW:    seq = {seq, PH_MEMADR, PH_MEMWRITE};
         OP_R:     seq = {seq, PH_EXECR, PH_ALUWB};
         OP_IALU:  seq = {seq, PH_EXECI, PH_ALUWB};
         OP_BR:    seq = {seq, PH_BRANCH};
         OP_JAL:   seq = {seq, PH_JAL, PH_ALUWB};
         OP_JALR:  seq = {seq, PH_JALR1, PH_JALR2, PH_ALUWB};
         OP_LUI:   seq = {seq, PH_LUI, PH_ALUWB};
         OP_AUIPC: seq = {seq, PH_ALUWB};
         default:  ;
      endcase
   endfunction

   // Output table: {ImmSrc, A, B, ALUOp, ResultSrc, AdrSrc, IRW, PCW, RegW, MemW, illegal}.
   function automatic logic [16:0] expect_out(input ph_t ph, input logic [6:0] op,
                                               input logic [2:0] f3, input logic z,
                                               input logic mr);
      logic [2:0] imm;
      logic [1:0] a, b, alu, res;
      logic       adr, irw, pcw, rgw, mw, ill;
      imm = (ph == PH_FETCH) ? 3'b000 : imm_type(op, f3);
      {a, b, alu, res, adr, irw, pcw, rgw, mw, ill} = '0;
      case (ph)
         PH_FETCH:    begin b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
         PH_DECODE:   begin a = 2'b01; b = 2'b01; ill = !is_legal(op); end
         PH_MEMADR:   begin a = 2'b10; b = 2'b01; end
         PH_MEMREAD:  begin adr = 1'b1; end
         PH_MEMWB:    begin res = 2'b01; rgw = 1'b1; end
         PH_MEMWRITE: begin adr = 1'b1; mw = 1'b1; end
         PH_EXECR:    begin a = 2'b10; alu = 2'b10; end
         PH_EXECI:    begin a = 2'b10; b = 2'b01; alu = 2'b10; end
         PH_ALUWB:    begin rgw = 1'b1; end
         PH_BRANCH:   begin
            a = 2'b10; alu = 2'b01;
            pcw = (f3 == 3'b000) ? z : ((f3 == 3'b001) ? !z : 1'b0);
         end
         PH_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
         PH_JALR1:    begin a = 2'b10; b = 2'b01; end
         PH_JALR2:    begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
         PH_LUI:      begin a = 2'b11; b = 2'b01; end
         default:     ;
      endcase
      return {imm, a, b, alu, res, adr, irw, pcw, rgw, mw, ill};
   endfunction

   // One clock cycle: entered just after a rising edge, drives inputs,
   // checks at the falling edge, returns just after the next rising edge.
   task automatic step(input ph_t ph, input logic [6:0] op, input logic [2:0] f3,
                       input logic mr, input logic z);
      u_bus.op        = op;
      u_bus.funct3    = f3;
      u_bus.mem_ready = mr;
      u_bus.Zero      = z;
      @(negedge clk);
      check($sformatf("%s op=%b f3=%b", ph.name(), op, f3), {15'd0, obs_vec()},
            {15'd0, expect_out(ph, op, f3, z, mr)});
      @(posedge clk);
      #1;
   endtask

   // Stall args: -1 picks randomly, otherwise the number of mem_ready-low cycles.
   // zf: -1 random Zero, otherwise forced value.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                            input int fetch_stall, input int mem_stall, input int zf);
      int   cycles;
      int   stalls;
      int   n_low;
      bit   wait_ph;
      logic mr, z;
      cycles = 0;
      stalls = 0;
      build_seq(op);
      foreach (seq[i]) begin
         wait_ph = seq[i] inside {PH_FETCH, PH_MEMREAD, PH_MEMWRITE};
         n_low = 0;
         if (wait_ph) begin
            n_low = (seq[i] == PH_FETCH) ? fetch_stall : mem_stall;
            if (n_low < 0) n_low = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         end
         for (int c = 0; c <= n_low; c++) begin
            mr = wait_ph ? (c == n_low) : 1'($urandom_range(0, 1));
            z  = (zf < 0) ? 1'($urandom_range(0, 1)) : zf[0];
            step(seq[i], op, f3, mr, z);
            cycles++;
            if (c < n_low) stalls++;
         end
      end
      check($sformatf("cycles op=%b", op), cycles, cpi_base(op) + stalls);
   endtask

   logic [6:0] ops[9] = '{OP_LW, OP_IALU, OP_AUIPC, OP_SW, OP_R, OP_LUI, OP_BR, OP_JALR, OP_JAL};

   initial begin
      logic [6:0] rop;
      u_bus.op        = OP_R;
      u_bus.funct3    = 3'b000;
      u_bus.mem_ready = 1'b1;
      u_bus.Zero      = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;

      // Held in reset with mem_ready high: nothing may be written.
      repeat (3) begin
         @(negedge clk);
         check("rst_enables", {27'd0, obs_enables()}, 32'd0);
         check("rst_immsrc", {29'd0, u_bus.ImmSrc}, 32'd0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;

      // add, lw with 2-cycle MEMREAD stall (7 cycles), beq/bne both ways.
      run_instr(OP_R, 3'b000, 0, 0, -1);
      run_instr(OP_LW, 3'b010, 0, 2, -1);
      run_instr(OP_BR, 3'b000, 0, 0, 1);
      run_instr(OP_BR, 3'b000, 0, 0, 0);
      run_instr(OP_BR, 3'b001, 0, 0, 1);
      run_instr(OP_BR, 3'b001, 0, 0, 0);
      run_instr(OP_BR, 3'b100, 0, 0, 1);
      run_instr(OP_IALU, 3'b001, 0, 0, -1);
      run_instr(OP_IALU, 3'b101, 0, 0, -1);
      run_instr(OP_IALU, 3'b000, 0, 0, -1);
      run_instr(OP_JAL, 3'b000, 0, 0, -1);
      run_instr(7'b1111111, 3'b000, 0, 0, -1);
      run_instr(OP_SW, 3'b010, 2, 3, -1);

      // sw interrupted by reset while MemWrite is waiting on memory.
      step(PH_FETCH, OP_SW, 3'b010, 1'b1, 1'b0);
      step(PH_DECODE, OP_SW, 3'b010, 1'b1, 1'b0);
      step(PH_MEMADR, OP_SW, 3'b010, 1'b1, 1'b0);
      u_bus.mem_ready = 1'b0;
      @(negedge clk);
      check("memwrite_before_rst", {31'd0, u_bus.MemWrite}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("memwrite_async_drop", {31'd0, u_bus.MemWrite}, 32'd0);
      check("enables_async_drop", {27'd0, obs_enables()}, 32'd0);
      u_bus.mem_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("rst_hold_enables", {27'd0, obs_enables()}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_instr(OP_SW, 3'b010, 0, 0, -1);

      // Random instruction stream with random stalls.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            do rop = 7'($urandom_range(0, 127)); while (is_legal(rop));
         end else begin
            rop = ops[$urandom_range(0, 8)];
         end
         run_instr(rop, 3'($urandom_range(0, 7)), -1, -1, -1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
